disparity_packer: RTL and testbench

//  - Sits directly downstream of the stereo2 census/Hamming core.
//  - Collects the per-pixel disparity/valid stream and packs DISP_W-bit disparities LSB-first into WORD_W-bit words.
//  - Buffers words in a FIFO_DEPTH-entry FIFO with a valid/ready output handshake toward the frame-store writer.
//  - Flushes a zero-padded partial word at every line end (falling edge of the camera line signal).

---
 rtl/disparity_packer.sv | 178 +++++++++++++++++
 tb/tb_disparity_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_packer.sv
// disparity_packer
//   Packs the per-pixel disparity stream from the stereo census/Hamming core into
//   WORD_W-bit words, LSB-first. Words are buffered in a FIFO_DEPTH-entry FIFO and
//   presented with a valid/ready handshake. At each line end (falling edge of 'line')
//   a partial word is flushed with its unused upper bits zero.
//
// Ports
//   pxclk       in   pixel clock, all logic on rising edge
//   reset       in   synchronous active-low reset
//   disparity   in   DISP_W-bit disparity sample
//   valid       in   sample qualifier
//   line        in   camera line-active signal
//   word        out  FIFO head word (0 when empty)
//   wordValid   out  FIFO non-empty
//   wordReady   in   consumer accepts head when wordValid && wordReady
//   lineDone    out  one-cycle pulse the cycle after a line falling edge
//   overflow    out  sticky, set when a word was dropped on a full FIFO
//   droppedCnt  out  (DISP_PACK_STATS_EN only) saturating dropped-word count
//   wordCnt     out  (DISP_PACK_STATS_EN only) wrapping popped-word count
//
// Build option
//   DISP_PACK_STATS_EN : adds droppedCnt/wordCnt statistics ports and counters.
module disparity_packer #(
    parameter int unsigned DISP_W     = 2,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              pxclk,
    input  logic              reset,
    input  logic [DISP_W-1:0] disparity,
    input  logic              valid,
    input  logic              line,
    output logic [WORD_W-1:0] word,
    output logic              wordValid,
    input  logic              wordReady,
    output logic              lineDone,
    output logic              overflow
`ifdef DISP_PACK_STATS_EN
    ,
    output logic [15:0]       droppedCnt,
    output logic [15:0]       wordCnt
`endif
);

    localparam int unsigned PER_WORD = WORD_W / DISP_W;
    localparam int unsigned SLOT_W   = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;

    localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(PER_WORD - 1);
    localparam logic [CNT_W-1:0]  DepthC   = CNT_W'(FIFO_DEPTH);

    // Packing state
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] part_q, part_d;
    logic              line_q;
    logic              line_done_q;
    logic              overflow_q, overflow_d;

    // FIFO state
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [WORD_W-1:0] packed_word;
    logic              complete;
    logic              fall;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              drop;

    always_comb begin
        // Current partial word with this cycle's sample merged into its slot.
        packed_word = part_q;
        if (valid) begin
            for (int i = 0; i < int'(PER_WORD); i++) begin
                if (slot_q == SLOT_W'(i)) begin
                    packed_word[i*DISP_W +: DISP_W] = disparity;
                end
            end
        end

        complete = valid && (slot_q == LastSlot);
        fall     = line_q && !line;
        // A completing sample already pushes; otherwise flush only if something is held.
        push     = complete || (fall && (valid || (slot_q != '0)));

        slot_d = slot_q;
        part_d = part_q;
        if (push) begin
            slot_d = '0;
            part_d = '0;
        end else if (valid) begin
            slot_d = slot_q + SLOT_W'(1);
            part_d = packed_word;
        end

        pop     = (count_q != '0) && wordReady;
        // A pop in the same cycle frees the slot, so full + push + pop loses nothing.
        push_ok = push && ((count_q != DepthC) || pop);
        drop    = push && !push_ok;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            slot_q      <= '0;
            part_q      <= '0;
            line_q      <= 1'b0;
            line_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            slot_q      <= slot_d;
            part_q      <= part_d;
            line_q      <= line;
            line_done_q <= fall;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while count_q != 0.
    always_ff @(posedge pxclk) begin
        if (reset && push_ok) begin
            mem_q[wr_ptr_q] <= packed_word;
        end
    end

    assign wordValid = (count_q != '0);
    assign word      = wordValid ? mem_q[rd_ptr_q] : '0;
    assign lineDone  = line_done_q;
    assign overflow  = overflow_q;

`ifdef DISP_PACK_STATS_EN
    logic [15:0] dropped_cnt_q, dropped_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        dropped_cnt_d = dropped_cnt_q;
        if (drop && (dropped_cnt_q != 16'hFFFF)) begin
            dropped_cnt_d = dropped_cnt_q + 16'd1;
        end
        word_cnt_d = pop ? word_cnt_q + 16'd1 : word_cnt_q;
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            dropped_cnt_q <= '0;
            word_cnt_q    <= '0;
        end else begin
            dropped_cnt_q <= dropped_cnt_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign droppedCnt = dropped_cnt_q;
    assign wordCnt    = word_cnt_q;
`endif

endmodule

// File: tb/tb_disparity_packer.sv
// Directed bench for disparity_packer (DISP_W=2, WORD_W=16, FIFO_DEPTH=8).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_disparity_packer;

    logic        pxclk = 1'b0;
    logic        reset;
    logic [1:0]  disparity;
    logic        valid;
    logic        line;
    logic [15:0] word;
    logic        wordValid;
    logic        wordReady;
    logic        lineDone;
    logic        overflow;
`ifdef DISP_PACK_STATS_EN
    logic [15:0] droppedCnt;
    logic [15:0] wordCnt;
`endif

    int total = 0;
    int bad   = 0;

    disparity_packer #(
        .DISP_W    (2),
        .WORD_W    (16),
        .FIFO_DEPTH(8)
    ) u_dut (
        .pxclk     (pxclk),
        .reset     (reset),
        .disparity (disparity),
        .valid     (valid),
        .line      (line),
        .word      (word),
        .wordValid (wordValid),
        .wordReady (wordReady),
        .lineDone  (lineDone),
        .overflow  (overflow)
`ifdef DISP_PACK_STATS_EN
        ,
        .droppedCnt(droppedCnt),
        .wordCnt   (wordCnt)
`endif
    );

    always #5 pxclk = ~pxclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pxclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Word k carries k[1:0] in slot 0 and k[3:2] in slot 1, so it packs to 16'h000k.
    // Optionally raises wordReady for the completing sample.
    task automatic send_word(input int k, input logic rdy_last);
        logic [3:0] kv;
        kv = 4'(k);
        for (int j = 0; j < 8; j++) begin
            valid     = 1'b1;
            disparity = (j == 0) ? kv[1:0] : (j == 1) ? kv[3:2] : 2'd0;
            if (j == 7 && rdy_last) wordReady = 1'b1;
            tick();
        end
        valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        disparity = 2'd0;
        valid     = 1'b0;
        line      = 1'b0;
        wordReady = 1'b0;
        tick();
        tick();
        check("rst_word", 32'(word), 32'h0);
        check("rst_wvalid", 32'(wordValid), 32'h0);
        check("rst_linedone", 32'(lineDone), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b1;

        // Basic packing: 0,1,2,3,0,1,2,3 -> E4E4, visible for exactly one cycle.
        wordReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid     = 1'b1;
            disparity = 2'(i % 4);
            if (i == 7) check("pack_not_early", 32'(wordValid), 32'h0);
            tick();
        end
        valid = 1'b0;
        check("pack_wvalid", 32'(wordValid), 32'h1);
        check("pack_word", 32'(word), 32'hE4E4);
        tick();
        check("pack_one_cycle", 32'(wordValid), 32'h0);

        // Line end with 11 samples of 3 -> FFFF then 003F.
        wordReady = 1'b0;
        line      = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            valid     = 1'b1;
            disparity = 2'd3;
            tick();
        end
        valid = 1'b0;
        line  = 1'b0;
        check("fall_no_pulse_yet", 32'(lineDone), 32'h0);
        tick();
        check("fall_linedone", 32'(lineDone), 32'h1);
        check("fall_word0", 32'(word), 32'hFFFF);
        tick();
        check("fall_linedone_clr", 32'(lineDone), 32'h0);
        wordReady = 1'b1;
        tick();
        check("fall_word1", 32'(word), 32'h003F);
        tick();
        check("fall_drained", 32'(wordValid), 32'h0);

        // Fall with empty partial word: pulse only, no push.
        line = 1'b1;
        tick();
        line = 1'b0;
        tick();
        check("empty_fall_linedone", 32'(lineDone), 32'h1);
        check("empty_fall_nopush", 32'(wordValid), 32'h0);

        // Completing sample coincides with fall: single word AAAA only.
        wordReady = 1'b0;
        line      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid     = 1'b1;
            disparity = 2'd2;
            if (i == 7) line = 1'b0;
            tick();
        end
        valid = 1'b0;
        check("cofall_word", 32'(word), 32'hAAAA);
        wordReady = 1'b1;
        tick();
        check("cofall_single", 32'(wordValid), 32'h0);

        // Overflow: 9 words into an 8-deep FIFO with no consumer.
        do_reset();
        wordReady = 1'b0;
        for (int k = 1; k <= 8; k++) send_word(k, 1'b0);
        check("ovf_not_yet", 32'(overflow), 32'h0);
        send_word(9, 1'b0);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_head_hold", 32'(word), 32'h0001);
`ifdef DISP_PACK_STATS_EN
        check("ovf_dropped_cnt", 32'(droppedCnt), 32'h1);
`endif
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_drain_%0d", k), 32'(word), 32'(k));
            wordReady = 1'b1;
            tick();
        end
        check("ovf_empty", 32'(wordValid), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
`ifdef DISP_PACK_STATS_EN
        check("ovf_word_cnt", 32'(wordCnt), 32'h8);
`endif

        // Reset mid-word discards the partial word.
        do_reset();
        wordReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid     = 1'b1;
            disparity = 2'd3;
            tick();
        end
        do_reset();
        check("midrst_overflow_clr", 32'(overflow), 32'h0);
        check("midrst_noflush", 32'(wordValid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            valid     = 1'b1;
            disparity = 2'd1;
            tick();
        end
        valid = 1'b0;
        check("midrst_word", 32'(word), 32'h5555);
        tick();
        check("midrst_single", 32'(wordValid), 32'h0);

        // Full FIFO, pop and push in the same cycle: no loss.
        do_reset();
        wordReady = 1'b0;
        for (int k = 1; k <= 8; k++) send_word(k, 1'b0);
        send_word(9, 1'b1);
        wordReady = 1'b0;
        check("fullpp_overflow", 32'(overflow), 32'h0);
        check("fullpp_head", 32'(word), 32'h0002);
`ifdef DISP_PACK_STATS_EN
        check("fullpp_dropped_cnt", 32'(droppedCnt), 32'h0);
`endif
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("fullpp_drain_%0d", k), 32'(word), 32'(k));
            wordReady = 1'b1;
            tick();
        end
        check("fullpp_empty", 32'(wordValid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
